// File: rtl/pla_sweep_bist.sv
// Exhaustive 64K-vector stimulus for the PLA with a 16-bit MISR over pla_f and a go/no-go compare.
// Latency: 65536*(SETTLE_CYCLES+1)+2 cycles from start to done (+16*(SETTLE_CYCLES+1) with PLA_SWEEP_CEN_EN).
// No backpressure: start is ignored while busy, abort always wins. Optional deselect check: PLA_SWEEP_CEN_EN.
module pla_sweep_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] SEED          = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected_sig,
  output logic [15:0] pla_i,
  output logic        pla_cen,
  input  logic [7:0]  pla_f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] vec_count,
  output logic        cen_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
`ifdef PLA_SWEEP_CEN_EN
    CEN_SETTLE,
    CEN_SAMPLE,
`endif
    FINISH,
    DONE
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] MISR_POLY   = 16'h1021;

  state_t      state, state_nx;
  logic [7:0]  settle_cnt;
  logic [15:0] vec_q;
  logic [15:0] sig_q;
  logic [15:0] misr_next;
  logic        pass_q;
  logic        cen_err_q;
  logic        start_go;
  logic        abort_go;
  logic        settle_end;

  assign start_go   = start & ~abort;
  assign abort_go   = abort & (state != IDLE);
  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign misr_next  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ {8'h00, pla_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_go) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:   if (start_go) state_nx = SETTLE;
        SETTLE: if (settle_end) state_nx = SAMPLE;
        SAMPLE: begin
          if (vec_q != 16'hFFFF) state_nx = SETTLE;
`ifdef PLA_SWEEP_CEN_EN
          else                   state_nx = CEN_SETTLE;
`else
          else                   state_nx = FINISH;
`endif
        end
`ifdef PLA_SWEEP_CEN_EN
        CEN_SETTLE: if (settle_end) state_nx = CEN_SAMPLE;
        CEN_SAMPLE: state_nx = (vec_q[3:0] == 4'hF) ? FINISH : CEN_SETTLE;
`endif
        FINISH: state_nx = DONE;
        DONE:   if (start_go) state_nx = SETTLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    pla_cen = 1'b1;
    pla_i   = 16'h0000;
    case (state)
      SETTLE, SAMPLE: begin
        busy    = 1'b1;
        pla_cen = 1'b0;
        pla_i   = vec_q;
      end
`ifdef PLA_SWEEP_CEN_EN
      // Deselected vectors replicate k across all four nibbles.
      CEN_SETTLE, CEN_SAMPLE: begin
        busy  = 1'b1;
        pla_i = {4{vec_q[3:0]}};
      end
`endif
      FINISH: busy = 1'b1;
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 8'h00;
      vec_q      <= 16'h0000;
      sig_q      <= SEED;
      pass_q     <= 1'b0;
      cen_err_q  <= 1'b0;
    end else if (abort_go) begin
      // Signature is deliberately kept so a debugger can inspect where the sweep stopped.
      settle_cnt <= 8'h00;
      vec_q      <= 16'h0000;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_go) begin
            settle_cnt <= 8'h00;
            vec_q      <= 16'h0000;
            sig_q      <= SEED;
            pass_q     <= 1'b0;
            cen_err_q  <= 1'b0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 8'h01;
        SAMPLE: begin
          sig_q      <= misr_next;
          settle_cnt <= 8'h00;
          vec_q      <= vec_q + 16'h0001;
        end
`ifdef PLA_SWEEP_CEN_EN
        CEN_SETTLE: settle_cnt <= settle_cnt + 8'h01;
        CEN_SAMPLE: begin
          if (pla_f != 8'hFF) cen_err_q <= 1'b1;
          settle_cnt <= 8'h00;
          vec_q      <= (vec_q[3:0] == 4'hF) ? 16'h0000 : vec_q + 16'h0001;
        end
`endif
        FINISH: pass_q <= (sig_q == expected_sig) & ~cen_err;
        default: ;
      endcase
    end
  end

  assign signature = sig_q;
  assign vec_count = vec_q;
  assign pass      = pass_q;

`ifdef PLA_SWEEP_CEN_EN
  assign cen_err = cen_err_q;
`else
  assign cen_err = 1'b0;
`endif

endmodule

// File: tb/tb_pla_sweep_bist.sv
// Bench for pla_sweep_bist: a stand-in PLA, directed MISR values and full-sweep go/no-go checks.
module tb_pla_sweep_bist;

  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expected_sig = 16'h0000;
  logic [15:0] pla_i;
  logic        pla_cen;
  logic [7:0]  pla_f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_count;
  logic        cen_err;

  logic        fault_on = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_sig;
  logic [15:0] fault_sig;
  logic [15:0] sig_at_800;

  pla_sweep_bist #(.SETTLE_CYCLES(2), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_sig(expected_sig), .pla_i(pla_i), .pla_cen(pla_cen), .pla_f(pla_f),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .vec_count(vec_count), .cen_err(cen_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_f(input logic [15:0] i);
    return i[7:0] ^ i[15:8] ^ {i[3:0], i[7:4]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] f);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {8'h00, f};
  endfunction

  // Stand-in PLA; outputs float high when deselected, with an injectable stuck-at-1 on f[3].
  assign pla_f = pla_cen ? 8'hFF
               : (ref_f(pla_i) | ((fault_on && pla_i == 16'h1234) ? 8'h08 : 8'h00));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit pulse_busy, output int cycles);
    bit pulsed;
    bit hold_checked;
    int hold;
    pulsed = 0;
    hold_checked = 0;
    hold = 0;
    cycles = 0;
    start = 1'b1;
    for (int n = 1; n <= 200000; n++) begin
      tick();
      start = 1'b0;
      if (n == 1) begin
        check("first_busy", busy, 1);
        check("first_cen", pla_cen, 0);
        check("first_pla_i", pla_i, 16'h0000);
        check("first_sig", signature, SEED);
      end
      if (n == 3) check("vec0_held", pla_i, 16'h0000);
      if (n == 4) begin
        check("vec1_idx", vec_count, 16'h0001);
        check("vec1_pla_i", pla_i, 16'h0001);
        check("sig_after_v0", signature, 16'hEFDF);
      end
      if (n == 7) check("sig_after_v1", signature, 16'hCF8E);
      if (pulse_busy && !pulsed && vec_count == 16'h0010) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (pla_i == 16'h1234) hold++;
      else if (hold != 0 && !hold_checked) begin
        check("hold_1234", hold, 3);
        hold_checked = 1;
      end
      if (done) begin
        cycles = n;
        break;
      end
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    int cyc;
    logic [15:0] s;
    logic [15:0] fs;
    s  = SEED;
    fs = SEED;
    for (int v = 0; v < 65536; v++) begin
      if (v == 16'h0800) sig_at_800 = s;
      s  = misr_step(s, ref_f(16'(v)));
      fs = misr_step(fs, ref_f(16'(v)) | ((v == 16'h1234) ? 8'h08 : 8'h00));
    end
    model_sig = s;
    fault_sig = fs;

    #1 rst_n = 1'b0;
    #2;
    check("rst_pla_i", pla_i, 16'h0000);
    check("rst_cen", pla_cen, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, SEED);
    check("rst_vec", vec_count, 16'h0000);
    check("rst_cen_err", cen_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a sweep.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("midsweep_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_cen", pla_cen, 1);
    check("mrst_pla_i", pla_i, 16'h0000);
    check("mrst_sig", signature, SEED);
    check("mrst_vec", vec_count, 16'h0000);
    check("mrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Abort at vector 0x0800.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10000 && vec_count != 16'h0800; n++) tick();
    check("reach_0800", vec_count, 16'h0800);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cen", pla_cen, 1);
    check("abort_pla_i", pla_i, 16'h0000);
    check("abort_vec", vec_count, 16'h0000);
    check("abort_sig_kept", signature, sig_at_800);
    tick();
    check("abort_idle_busy", busy, 0);

    // Clean sweep with a busy-time start pulse that must be ignored.
    expected_sig = model_sig;
    sweep(1'b1, cyc);
    check("latency", cyc, 196610);
    check("run1_pass", pass, 1);
    check("run1_sig", signature, model_sig);
    check("run1_busy", busy, 0);
    check("run1_cen", pla_cen, 1);
    check("run1_pla_i", pla_i, 16'h0000);
    check("run1_vec", vec_count, 16'h0000);
    check("run1_cen_err", cen_err, 0);
    repeat (3) tick();
    check("run1_done_held", done, 1);
    check("run1_pass_held", pass, 1);

    // Restart from DONE with f[3] stuck at 1 on vector 0x1234.
    fault_on = 1'b1;
    sweep(1'b0, cyc);
    check("run2_latency", cyc, 196610);
    check("run2_pass", pass, 0);
    check("run2_sig", signature, fault_sig);
    check("run2_sig_differs", signature != model_sig, 1);
    fault_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_sweep_bist.md
Name: pla_sweep_bist

Overview:
- On-chip built-in self-test stimulus generator and signature compactor, directly upstream of the C64 PLA design.
- Drives all 65536 combinations onto the 16 i-lines with chip-enable asserted, and waits a programmable settle time per vector.
- Compacts the 8 f-lines into a 16-bit MISR signature.
- Compares the final signature against an expected value, giving silicon go/no-go without an external 64K-vector tester.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling (1..255).
- SEED, 16'hFFFF, MISR initial value loaded on start.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins sweep when idle or done
- abort  input  1  level; terminates sweep and returns to IDLE
- expected_sig  input  16  golden signature, sampled in FINISH
- pla_i  output  16  PLA input vector
- pla_cen  output  1  PLA chip enable, active low
- pla_f  input  8  PLA outputs
- busy  output  1  high while sweeping
- done  output  1  high from completion until the next start, abort or reset
- pass  output  1  valid when done=1; signature matched (and cen check passed, if enabled)
- signature  output  16  current MISR value
- vec_count  output  16  index of the vector currently applied
- cen_err  output  1  deselect check failed (0 when the feature is absent)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, pla_i=0, pla_cen=1, busy=0, done=0, pass=0, signature=SEED, vec_count=0, cen_err=0.
- State IDLE or DONE, start=1:
  - next cycle enters SETTLE.
  - pla_i=0, pla_cen=0, signature=SEED, settle counter=0, busy=1, done=0, pass=0, cen_err=0.
- SETTLE:
  - pla_i holds vec_count; counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - Each vector is therefore held SETTLE_CYCLES+1 cycles.
- SAMPLE: one cycle; MISR updates from pla_f on this edge:
  - fb = signature[15]
  - sig_next = {signature[14:0],1'b0} ^ (fb ? 16'h1021 : 0) ^ {8'h00, pla_f}
- SAMPLE, vec_count != 16'hFFFF: vec_count+1 (pla_i follows), counter=0, return to SETTLE.
- SAMPLE, vec_count == 16'hFFFF:
  - go to FINISH (or CENCHK when the feature is enabled).
  - vec_count wraps to 0; no further MISR update.
- FINISH: one cycle.
  - pass <= (signature == expected_sig) & ~cen_err.
  - done=1, busy=0, pla_cen=1, pla_i=0; next state DONE.
- DONE: holds all results. A new start restarts the sweep from the reset-like initial values above.
- Latency, start pulse to done rising: 65536*(SETTLE_CYCLES+1)+2 cycles (196610 at default), plus 16*(SETTLE_CYCLES+1) cycles when the feature is enabled.
- start while busy: ignored.
- abort (any state except IDLE):
  - next cycle IDLE, pla_cen=1, pla_i=0, vec_count=0, busy=0, done=0, pass=0.
  - signature keeps its last value for debug.
- abort and start in the same cycle: abort wins.
- Reset mid-sweep: immediate return to reset values, no partial result.
- pla_f is sampled only in SAMPLE; changes in SETTLE have no effect.

Optional Feature:
- Macro PLA_SWEEP_CEN_EN.
- When defined:
  - After the last vector, state CENCHK runs 16 extra vectors with pla_cen=1 and pla_i = {k,k,k,k} for k=0..15.
  - Each vector uses the same SETTLE/SAMPLE timing.
  - In each SAMPLE, pla_f != 8'hFF sets sticky cen_err. The MISR is not updated.
  - Then FINISH.
- When undefined: CENCHK is absent, pla_cen=0 for the whole sweep, cen_err is tied 0.

Test Plan:
- Reset, pulse start, PLA design behind the block, expected_sig = value from a behavioural MISR model over the reference PLA -> done rises after exactly 196610 cycles (SETTLE_CYCLES=2, feature off), pass=1, signature=expected_sig.
- Same sweep with expected_sig = model value ^ 16'h0001 -> done=1, pass=0, signature unchanged from the model.
- Force pla_f[3] stuck-at-1 only for vector 16'h1234 -> signature differs from the model, pass=0. Check pla_i=16'h1234 is held for 3 cycles.
- Assert abort while vec_count=16'h0800 -> next cycle busy=0, done=0, pla_cen=1, pla_i=0. A new start reruns and passes.
- Pulse start at vec_count=16'h0010 while busy -> no restart; final done time and signature are identical to an uninterrupted run. Pulse rst_n low mid-sweep -> all outputs at reset values immediately.
- With PLA_SWEEP_CEN_EN, force pla_f=8'hFE during the deselect vector k=5 -> cen_err=1, pass=0 even with a matching signature.
